alu_iter: RTL

- Next-generation integer ALU for the RVOOM execution cluster.
- Single-cycle ops are handled as in the current ALU: add, logic, compare, min/max, shift-add, pc-relative add.
- Adds an iterative carry-less multiply unit (clmul/clmulh/clmulr) with a ready handshake, a configurable bits-per-cycle step and per-commit-slot kill.
- Sits between the issue queue and the result/bypass bus.

---
 rtl/alu_iter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// Integer ALU: registered single-cycle ops (add/logic/compare/min-max/shift-add/pc-add)
// plus an iterative carry-less multiplier with ready handshake and per-slot kill.
module alu_iter #(
  parameter int RV         = 64,
  parameter int VA_SZ      = 48,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int CNTRL_SIZE = 7,
  parameter int CL_STEP    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  ready,
  input  logic [CNTRL_SIZE-1:0] control,
  input  logic [LNCOMMIT-1:0]   rd,
  input  logic                  makes_rd,
  input  logic                  needs_rs2,
  input  logic [RV-1:0]         r1,
  input  logic [RV-1:0]         r2,
  input  logic [31:0]           immed,
  input  logic [VA_SZ-2:0]      pc,
  input  logic                  rv32,
  input  logic [NCOMMIT-1:0]    commit_kill,
  output logic [RV-1:0]         result,
  output logic [LNCOMMIT-1:0]   res_rd,
  output logic                  res_makes_rd
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [RV-1:0] LoMask = RV'({32{1'b1}});

  function automatic logic [RV-1:0] sext32(input logic [RV-1:0] x);
    logic [RV-1:0] y;
    y = x;
    for (int i = 32; i < RV; i++) y[i] = x[31];
    return y;
  endfunction

  // Single-cycle datapath
  logic [3:0]          op;
  logic                word, narrow, inv_b, lt_s, lt_u, lt;
  logic [RV-1:0]       imm_ext, b_raw, b_op, cin_v, a_s, b_s, a_u, b_u, shadd_a, pc_ext;
  logic [RV-1:0]       alu_raw, alu_res;
  logic [RV+VA_SZ-1:0] pc_big;

  always_comb begin
    op      = {control[5], control[2:0]};
    word    = control[4];
    narrow  = rv32 | word;
    // control[3] selects unsigned for compares, so inversion only applies to arithmetic/logic
    inv_b   = control[3] & ~(((op >= 4'd4) && (op <= 4'd7)) || (op == 4'd13));
    imm_ext = sext32(RV'(immed));
    b_raw   = needs_rs2 ? r2 : imm_ext;
    b_op    = inv_b ? ~b_raw : b_raw;
    cin_v   = RV'(inv_b);
    a_s     = narrow ? sext32(r1) : r1;
    b_s     = narrow ? sext32(b_raw) : b_raw;
    a_u     = narrow ? (r1 & LoMask) : r1;
    b_u     = narrow ? (b_raw & LoMask) : b_raw;
    lt_s    = $signed(a_s) < $signed(b_s);
    lt_u    = a_u < b_u;
    lt      = control[3] ? lt_u : lt_s;
    shadd_a = word ? (r1 & LoMask) : r1;
    pc_big  = {{RV{pc[VA_SZ-2]}}, pc, 1'b0};
    pc_ext  = pc_big[RV-1:0];
    alu_raw = '0;
    case (op)
      4'd0:                alu_raw = r1 + b_op + cin_v;
      4'd1:                alu_raw = r1 ^ b_op;
      4'd2:                alu_raw = r1 & b_op;
      4'd3:                alu_raw = r1 | b_op;
      4'd4:                alu_raw = RV'(lt_s);
      4'd5:                alu_raw = RV'(lt_u);
      4'd6:                alu_raw = lt ? r1 : b_raw;
      4'd7:                alu_raw = lt ? b_raw : r1;
      4'd8:                alu_raw = pc_ext + b_op + cin_v;
      4'd9, 4'd10, 4'd11:  alu_raw = (shadd_a << op[1:0]) + b_op + cin_v;
      4'd12:               alu_raw = (r1 + b_op + cin_v) & LoMask;
      default:             alu_raw = '0;
    endcase
    alu_res = (rv32 | (word & (op != 4'd12))) ? sext32(alu_raw) : alu_raw;
  end

  // Clmul and output state
  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d, sh;
  logic [2*RV-1:0]     acc_q, acc_d, a_q, a_d, partial, sel;
  logic [RV-1:0]       b_q, b_d, cl_res;
  logic [LNCOMMIT-1:0] rd_q, rd_d, p_rd_q, p_rd_d, res_rd_q, res_rd_d;
  logic                mk_q, mk_d, r32_q, r32_d, p_valid_q, p_valid_d, p_mk_q, p_mk_d;
  logic                res_mk_q, res_mk_d;
  logic [1:0]          var_q, var_d;
  logic [RV-1:0]       p_res_q, p_res_d, result_q, result_d;
  logic                unused_bits;

  assign unused_bits = ^{control[CNTRL_SIZE-1:6], pc_big[RV+VA_SZ-1:RV], sel[2*RV-1:RV]};

  always_comb begin
    partial = '0;
    for (int i = 0; i < CL_STEP; i++) begin
      if (b_q[i]) partial = partial ^ (a_q << i);
    end
    case (var_q)
      2'd1:    sh = r32_q ? 8'd32 : 8'(RV);
      2'd2:    sh = r32_q ? 8'd31 : 8'(RV - 1);
      default: sh = 8'd0;
    endcase
    sel    = acc_q >> sh;
    cl_res = (var_q == 2'd3) ? '0 : (r32_q ? sext32(sel[RV-1:0]) : sel[RV-1:0]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    mk_d      = mk_q;
    var_d     = var_q;
    r32_d     = r32_q;
    p_valid_d = 1'b0;
    p_res_d   = p_res_q;
    p_rd_d    = p_rd_q;
    p_mk_d    = 1'b0;
    result_d  = result_q;
    res_rd_d  = res_rd_q;
    res_mk_d  = 1'b0;
    // Pipe stage and DONE can never be live together: pipe fills only from IDLE.
    if (p_valid_q) begin
      result_d = p_res_q;
      res_rd_d = p_rd_q;
      res_mk_d = p_mk_q;
    end
    case (state_q)
      StIdle: begin
        if (enable) begin
          if (op == 4'd13) begin
            if (!commit_kill[rd]) begin
              state_d = StRun;
              cnt_d   = rv32 ? 8'(32 / CL_STEP) : 8'(RV / CL_STEP);
              acc_d   = '0;
              a_d     = {{RV{1'b0}}, (rv32 ? (r1 & LoMask) : r1)};
              b_d     = rv32 ? (b_raw & LoMask) : b_raw;
              rd_d    = rd;
              mk_d    = makes_rd;
              var_d   = immed[1:0];
              r32_d   = rv32;
            end
          end else begin
            p_valid_d = 1'b1;
            p_res_d   = alu_res;
            p_rd_d    = rd;
            p_mk_d    = makes_rd & ~commit_kill[rd];
          end
        end
      end
      StRun: begin
        if (commit_kill[rd_q]) begin
          state_d = StIdle;
        end else begin
          acc_d = acc_q ^ partial;
          a_d   = a_q << CL_STEP;
          b_d   = b_q >> CL_STEP;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!commit_kill[rd_q]) begin
          result_d = cl_res;
          res_rd_d = rd_q;
          res_mk_d = mk_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      mk_q      <= 1'b0;
      var_q     <= '0;
      r32_q     <= 1'b0;
      p_valid_q <= 1'b0;
      p_res_q   <= '0;
      p_rd_q    <= '0;
      p_mk_q    <= 1'b0;
      result_q  <= '0;
      res_rd_q  <= '0;
      res_mk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      mk_q      <= mk_d;
      var_q     <= var_d;
      r32_q     <= r32_d;
      p_valid_q <= p_valid_d;
      p_res_q   <= p_res_d;
      p_rd_q    <= p_rd_d;
      p_mk_q    <= p_mk_d;
      result_q  <= result_d;
      res_rd_q  <= res_rd_d;
      res_mk_q  <= res_mk_d;
    end
  end

  assign ready        = (state_q == StIdle);
  assign result       = result_q;
  assign res_rd       = res_rd_q;
  assign res_makes_rd = res_mk_q;

endmodule
